// File: rtl/dmem_arb_51.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access in flight at a time: read takes 2 cycles, write WR_CYCLES+1.
module dmem_arb_51 #(
   parameter int MEM_TOP   = 2000,
   parameter int WR_CYCLES = 2
) (
   input  logic        clk_51,
   input  logic        rst_51,
   input  logic        req0_51,
   input  logic        req1_51,
   input  logic        we0_51,
   input  logic        we1_51,
   input  logic [31:0] addr0_51,
   input  logic [31:0] addr1_51,
   input  logic [31:0] wdata0_51,
   input  logic [31:0] wdata1_51,
   output logic        gnt0_51,
   output logic        gnt1_51,
   output logic        done0_51,
   output logic        done1_51,
   output logic        err0_51,
   output logic        err1_51,
   output logic [31:0] rdata0_51,
   output logic [31:0] rdata1_51,
   output logic [31:0] mem_waddr_51,
   output logic [31:0] mem_wdata_51,
   output logic        mem_write_51,
   output logic [31:0] mem_raddr_51,
   input  logic [31:0] mem_rdata_51
);

   localparam logic [31:0] MEM_TOP_W = 32'(MEM_TOP);
   localparam logic [15:0] WR_N      = 16'(WR_CYCLES);

   typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

   state_t      state;
   logic        ptr;
   logic        sel;
   logic [15:0] wr_cnt;

   logic        fire;
   logic        fire_idx;
   logic        f_we;
   logic [31:0] f_addr;
   logic [31:0] f_wdata;

   // Pointer holder wins a tie; a lone requester always wins.
   always_comb begin
      gnt0_51 = 1'b0;
      gnt1_51 = 1'b0;
      if (state == IDLE) begin
         if (req0_51 && (!req1_51 || !ptr))
            gnt0_51 = 1'b1;
         else if (req1_51)
            gnt1_51 = 1'b1;
      end
   end

   assign fire     = gnt0_51 | gnt1_51;
   assign fire_idx = gnt1_51;
   assign f_we     = fire_idx ? we1_51    : we0_51;
   assign f_addr   = fire_idx ? addr1_51  : addr0_51;
   assign f_wdata  = fire_idx ? wdata1_51 : wdata0_51;

   always_ff @(posedge clk_51 or posedge rst_51) begin
      if (rst_51) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         sel          <= 1'b0;
         wr_cnt       <= '0;
         done0_51     <= 1'b0;
         done1_51     <= 1'b0;
         err0_51      <= 1'b0;
         err1_51      <= 1'b0;
         rdata0_51    <= '0;
         rdata1_51    <= '0;
         mem_waddr_51 <= '0;
         mem_wdata_51 <= '0;
         mem_write_51 <= 1'b0;
         mem_raddr_51 <= '0;
      end else begin
         done0_51     <= 1'b0;
         done1_51     <= 1'b0;
         err0_51      <= 1'b0;
         err1_51      <= 1'b0;
         mem_write_51 <= 1'b0;
         case (state)
            IDLE: begin
               if (fire) begin
                  sel <= fire_idx;
                  ptr <= ~fire_idx;
                  if (f_addr > MEM_TOP_W) begin
                     state <= ERR;
                  end else if (f_we) begin
                     state        <= WR;
                     mem_waddr_51 <= f_addr;
                     mem_wdata_51 <= f_wdata;
                     mem_write_51 <= 1'b1;
                     wr_cnt       <= 16'd1;
                  end else begin
                     state        <= RD;
                     mem_raddr_51 <= f_addr;
                  end
               end
            end
            RD: begin
               state <= IDLE;
               if (sel) begin
                  done1_51  <= 1'b1;
                  rdata1_51 <= mem_rdata_51;
               end else begin
                  done0_51  <= 1'b1;
                  rdata0_51 <= mem_rdata_51;
               end
            end
            WR: begin
               if (wr_cnt >= WR_N) begin
                  state <= IDLE;
                  if (sel) done1_51 <= 1'b1;
                  else     done0_51 <= 1'b1;
               end else begin
                  wr_cnt <= wr_cnt + 16'd1;
               end
            end
            ERR: begin
               state <= IDLE;
               if (sel) begin
                  done1_51  <= 1'b1;
                  err1_51   <= 1'b1;
                  rdata1_51 <= '0;
               end else begin
                  done0_51  <= 1'b1;
                  err0_51   <= 1'b1;
                  rdata0_51 <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
